// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life generation sequencer.
//   state_t  : sequencer FSM states
//   ALIVE/DEAD : cell value encoding
//   wrap_dec/wrap_inc : toroidal index helpers for row/column +-1
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic ALIVE = 1'b1;
  localparam logic DEAD  = 1'b0;

  // index - 1 on a ring of n entries
  function automatic int wrap_dec(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

  // index + 1 on a ring of n entries
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/life_cell_next.sv
// Combinational Life rule for one cell.
//   i_nbrs  : the 8 neighbour states (any order)
//   i_alive : current state of the centre cell
//   o_next  : next state, born on 3 neighbours, survives on 2 or 3
module life_cell_next
  import life_pkg::*;
(
  input  logic [7:0] i_nbrs,
  input  logic       i_alive,
  output logic       o_next
);

  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      w_cnt = w_cnt + {3'b000, i_nbrs[k]};
    end
  end

  assign o_next = ((w_cnt == 4'd3) || ((i_alive == ALIVE) && (w_cnt == 4'd2))) ? ALIVE : DEAD;

endmodule

// File: rtl/life_gen_sequencer.sv
// Game of Life generation controller on a toroidal ROWS x COLS grid.
// Evaluates one cell per cycle into a next buffer and commits a whole
// generation at once.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_load_en/row/data : row write into the current grid (IDLE only)
//   i_step, i_run      : single generation request / free-running level
//   o_busy, o_done     : SCAN or COMMIT active / new generation visible
//   o_gen_count        : generations committed since reset or last load
//   o_grid             : current grid, bit r*COLS+c = cell (r,c)
//
// state  | meaning
// IDLE   | waiting; loads accepted, step/run start a generation
// SCAN   | evaluating cell (r_row,r_col) into the next buffer
// COMMIT | next buffer copied to current, generation counted
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int ROWS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load_en,
  input  logic [$clog2(ROWS)-1:0]   i_load_row,
  input  logic [COLS-1:0]           i_load_data,
  input  logic                      i_step,
  input  logic                      i_run,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [GEN_W-1:0]          o_gen_count,
  output logic [ROWS*COLS-1:0]      o_grid
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(N);

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [N-1:0]     r_cur;
  logic [N-1:0]     r_nxt;
  logic             r_busy;
  logic             r_done;
  logic [GEN_W-1:0] r_gen;

  int               w_r, w_c, w_rm, w_rp, w_cm, w_cp;
  logic [7:0]       w_nbrs;
  logic             w_centre;
  logic             w_next;
  logic [IW-1:0]    w_cell;
  logic [IW-1:0]    w_load_base;
  logic             w_load_ok;

  function automatic logic [IW-1:0] cell_idx(input int r, input int c);
    return IW'(r * COLS + c);
  endfunction

  // Neighbourhood of the scan cell, always read from the stable current buffer
  always_comb begin
    w_r      = int'(r_row);
    w_c      = int'(r_col);
    w_rm     = wrap_dec(w_r, ROWS);
    w_rp     = wrap_inc(w_r, ROWS);
    w_cm     = wrap_dec(w_c, COLS);
    w_cp     = wrap_inc(w_c, COLS);
    w_nbrs   = {r_cur[cell_idx(w_rm, w_cm)], r_cur[cell_idx(w_rm, w_c)],
                r_cur[cell_idx(w_rm, w_cp)], r_cur[cell_idx(w_r,  w_cm)],
                r_cur[cell_idx(w_r,  w_cp)], r_cur[cell_idx(w_rp, w_cm)],
                r_cur[cell_idx(w_rp, w_c)],  r_cur[cell_idx(w_rp, w_cp)]};
    w_centre = r_cur[cell_idx(w_r, w_c)];
    w_cell   = cell_idx(w_r, w_c);
  end

  assign w_load_ok   = (int'(i_load_row) < ROWS);
  assign w_load_base = IW'(int'(i_load_row) * COLS);

  life_cell_next u_rule (
    .i_nbrs  (w_nbrs),
    .i_alive (w_centre),
    .o_next  (w_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gen   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // a load in the same cycle as step/run swallows the request
          if (i_load_en) begin
            if (w_load_ok) begin
              r_cur[w_load_base +: COLS] <= i_load_data;
              r_gen                      <= '0;
            end
          end else if (i_step || i_run) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        SCAN: begin
          r_nxt[w_cell] <= w_next;
          if (r_col == CW'(COLS - 1)) begin
            r_col <= '0;
            if (r_row == RW'(ROWS - 1)) begin
              r_row   <= '0;
              r_state <= COMMIT;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        COMMIT: begin
          r_cur  <= r_nxt;
          r_gen  <= r_gen + 1'b1;
          r_done <= 1'b1;
          if (i_run) begin
            r_state <= SCAN;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_gen_count = r_gen;
  assign o_grid      = r_cur;

endmodule

// File: tb/tb_life_gen_sequencer.sv
module tb_life_gen_sequencer;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic        clk = 1'b0;
  logic        rst, load_en, step, run;
  logic [2:0]  load_row;
  logic [7:0]  load_data;
  logic        busy, done, busy2, done2;
  logic [15:0] gen;
  logic [1:0]  gen2;
  logic [63:0] grid, grid2;

  always #5 clk = ~clk;

  life_gen_sequencer #(.COLS(8), .ROWS(8), .GEN_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_row(load_row),
    .i_load_data(load_data), .i_step(step), .i_run(run),
    .o_busy(busy), .o_done(done), .o_gen_count(gen), .o_grid(grid));

  // narrow generation counter, same stimulus
  life_gen_sequencer #(.COLS(8), .ROWS(8), .GEN_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_row(load_row),
    .i_load_data(load_data), .i_step(step), .i_run(run),
    .o_busy(busy2), .o_done(done2), .o_gen_count(gen2), .o_grid(grid2));

  int checks = 0;
  int errors = 0;

  // reference model: plain 2D array, neighbours by modular arithmetic
  bit mdl [ROWS][COLS];
  int mgen;

  function automatic logic [63:0] mdl_vec();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = mdl[r][c];
    return v;
  endfunction

  function automatic void mdl_set(input logic [63:0] g);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mdl[r][c] = g[r*COLS+c];
    mgen = 0;
  endfunction

  function automatic void mdl_step();
    bit nx [ROWS][COLS];
    int n;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(mdl[(r+dr+ROWS)%ROWS][(c+dc+COLS)%COLS]);
        nx[r][c] = (n == 3) || (mdl[r][c] && n == 2);
      end
    mdl  = nx;
    mgen = mgen + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_grid(input logic [63:0] g);
    for (int r = 0; r < ROWS; r++) begin
      load_en   = 1'b1;
      load_row  = 3'(r);
      load_data = g[r*8 +: 8];
      tick();
    end
    load_en = 1'b0;
    mdl_set(g);
  endtask

  // waits up to 200 cycles for done; lat = cycles since caller's last edge, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_step(output int lat);
    chk("busy_before_step", busy, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("busy_rise", busy, 1'b1);
    wait_done(lat);
    if (lat > 0) lat = lat + 1;
    mdl_step();
  endtask

  typedef struct {
    string       name;
    logic [63:0] init;
    int          steps;
    logic [63:0] exp_grid;
    logic [15:0] exp_gen;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat, ndone, prev, bad_int, busy_drop, cnt;
    logic [63:0] g, glider;

    rst = 1'b1; load_en = 1'b0; step = 1'b0; run = 1'b0;
    load_row = '0; load_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_grid", grid, 64'd0);
    chk("reset_gen", {48'd0, gen}, 64'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    tbl[0] = '{"blinker_1", 64'h0000_0000_1C00_0000, 1, 64'h0000_0008_0808_0000, 16'd1};
    tbl[1] = '{"blinker_2", 64'h0000_0000_1C00_0000, 2, 64'h0000_0000_1C00_0000, 16'd2};
    tbl[2] = '{"corners_1", 64'h0100_0000_0000_0081, 1, 64'h8100_0000_0000_0081, 16'd1};
    tbl[3] = '{"corners_2", 64'h0100_0000_0000_0081, 2, 64'h8100_0000_0000_0081, 16'd2};

    foreach (tbl[i]) begin
      load_grid(tbl[i].init);
      chk({tbl[i].name, "_load"}, grid, tbl[i].init);
      chk({tbl[i].name, "_gen_clr"}, {48'd0, gen}, 64'd0);
      for (int s = 0; s < tbl[i].steps; s++) begin
        run_step(lat);
        chk({tbl[i].name, "_latency"}, lat, 66);
      end
      chk({tbl[i].name, "_grid"}, grid, tbl[i].exp_grid);
      chk({tbl[i].name, "_model"}, grid, mdl_vec());
      chk({tbl[i].name, "_gen"}, {48'd0, gen}, {48'd0, tbl[i].exp_gen});
      tick();
      chk({tbl[i].name, "_done_width"}, done, 1'b0);
      chk({tbl[i].name, "_busy_fall"}, busy, 1'b0);
    end

    // random grids against the reference model
    for (int t = 0; t < 6; t++) begin
      g = {$urandom, $urandom};
      load_grid(g);
      chk("rand_load", grid, g);
      cnt = 1 + int'($urandom_range(2, 0));
      for (int s = 0; s < cnt; s++) begin
        run_step(lat);
        chk("rand_grid", grid, mdl_vec());
        chk("rand_gen", {48'd0, gen}, 64'(mgen));
      end
    end

    // generation counter wrap on the 2-bit instance
    load_grid(64'h0000_0000_1C00_0000);
    for (int s = 0; s < 4; s++) begin
      run_step(lat);
      chk("gen2_wrap", {62'd0, gen2}, 64'((s + 1) % 4));
      chk("gen2_grid", grid2, mdl_vec());
    end

    // glider free-running for 32 generations returns to its start
    glider = 64'h0000_0000_0007_0402;
    load_grid(glider);
    run = 1'b1;
    tick();
    ndone = 0; prev = -1; bad_int = 0; busy_drop = 0;
    for (int k = 1; k <= 3000 && ndone < 32; k++) begin
      tick();
      if (!busy) busy_drop = 1;
      if (done) begin
        ndone++;
        mdl_step();
        if (prev < 0) chk("glider_first_latency", 64'(k + 1), 64'd66);
        else if (k - prev != 65) bad_int++;
        prev = k;
      end
    end
    chk("glider_ndone", 64'(ndone), 64'd32);
    chk("glider_period_bad", 64'(bad_int), 64'd0);
    chk("glider_busy_drop", 64'(busy_drop), 64'd0);
    chk("glider_grid", grid, glider);
    chk("glider_model", grid, mdl_vec());
    chk("glider_gen", {48'd0, gen}, 64'd32);
    run = 1'b0;
    wait_done(lat);
    mdl_step();
    chk("glider_stop_grid", grid, mdl_vec());
    chk("glider_stop_gen", {48'd0, gen}, 64'd33);
    tick();
    chk("glider_stop_busy", busy, 1'b0);

    // load and step during SCAN are ignored
    g = {$urandom, $urandom};
    load_grid(g);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (9) tick();
    load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; step = 1'b1;
    tick();
    load_en = 1'b0; step = 1'b0;
    wait_done(lat);
    mdl_step();
    chk("ignore_grid", grid, mdl_vec());
    chk("ignore_gen", {48'd0, gen}, 64'd1);
    cnt = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("ignore_no_extra", 64'(cnt), 64'd0);

    // load wins over step in the same cycle; then reset mid-SCAN
    load_en = 1'b1; load_row = 3'd2; load_data = 8'h3C; step = 1'b1;
    tick();
    load_en = 1'b0; step = 1'b0;
    chk("prio_row2", {56'd0, grid[23:16]}, 64'h3C);
    chk("prio_gen", {48'd0, gen}, 64'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy) cnt++;
      tick();
    end
    chk("prio_busy", 64'(cnt), 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (18) tick();
    chk("scan_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_grid", grid, 64'd0);
    chk("rst_gen", {48'd0, gen}, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_grid2", grid2, 64'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("rst_no_done", 64'(cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
